// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: turns a debounced button level into press / release /
// long-press (and optionally auto-repeat) events, with sticky W1C pending
// flags, a maskable level interrupt and a wrapping press counter.
// Optional feature macro: BTN_REPEAT_EN (auto-repeat while HELD).
module btn_event_ctrl #(
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 8,
  parameter int TMR_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_debounced,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic             repeat_pulse,
  output logic             held,
  output logic [2:0]       pending,
  input  logic [2:0]       pend_clr,
  input  logic [2:0]       irq_en,
  output logic             irq,
  output logic [CNT_W-1:0] press_count,
  input  logic             cnt_clr
);

  typedef enum logic [1:0] {
    S_LOCKOUT = 2'd0,
    S_IDLE    = 2'd1,
    S_PRESS   = 2'd2,
    S_HELD    = 2'd3
  } state_t;

  // Terminal timer values; the timer starts at 0 on state entry.
  localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

  state_t             state_q, state_d;
  logic               btn_prev_q;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               long_q, long_d;
  logic               repeat_q, repeat_d;
  logic [2:0]         pending_q, pending_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rise, fall, inc;

  assign rise = btn_debounced & ~btn_prev_q;
  assign fall = ~btn_debounced & btn_prev_q;

`ifndef BTN_REPEAT_EN
  // Repeat period is only meaningful with auto-repeat built in.
  logic unused_rep;
  assign unused_rep = ^REP_LAST;
`endif

  // Next-state and event decode; a fall always beats any timer threshold.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      S_LOCKOUT: begin
        // A button held through reset must be seen low before it can count.
        if (!btn_debounced) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (rise) begin
          state_d = S_PRESS;
          timer_d = '0;
          press_d = 1'b1;
        end
      end
      S_PRESS: begin
        if (fall) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
        end else if (timer_q == LONG_LAST) begin
          state_d = S_HELD;
          long_d  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_HELD: begin
        if (fall) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
        end
`ifdef BTN_REPEAT_EN
        else if (timer_q == REP_LAST) begin
          repeat_d = 1'b1;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
`endif
      end
      default: state_d = S_LOCKOUT;
    endcase
  end

  // Flags and counter see the same-edge pulses, so a set beats a clear.
  always_comb begin
    inc       = press_d | repeat_d;
    pending_d = (pending_q & ~pend_clr) | {long_d, release_d, inc};
    if (cnt_clr) begin
      count_d = inc ? CNT_W'(1) : '0;
    end else begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, inc};
    end
  end

  // State, timer, registered pulses, flags and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOCKOUT;
      btn_prev_q <= 1'b0;
      timer_q    <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      pending_q  <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= btn_debounced;
      timer_q    <= timer_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      pending_q  <= pending_d;
      count_q    <= count_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = (state_q == S_HELD);
  assign pending       = pending_q;
  assign irq           = |(pending_q & irq_en);
  assign press_count   = count_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Scoreboard bench for btn_event_ctrl: the driver applies one input set per
// cycle, runs a behavioural model (press age counted in cycles) and queues
// the expected outputs; the monitor pops one entry per clock and compares.
module tb_btn_event_ctrl;

  localparam int LONG   = 10;
  localparam int REPEAT = 4;
  localparam int CNT_W  = 2;
  localparam int TMR_W  = 8;
`ifdef BTN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             btn_debounced;
  logic             press_pulse, release_pulse, long_pulse, repeat_pulse, held;
  logic [2:0]       pending;
  logic [2:0]       pend_clr;
  logic [2:0]       irq_en;
  logic             irq;
  logic [CNT_W-1:0] press_count;
  logic             cnt_clr;

  btn_event_ctrl #(
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REPEAT),
    .CNT_W        (CNT_W),
    .TMR_W        (TMR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_debounced(btn_debounced),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .pending      (pending),
    .pend_clr     (pend_clr),
    .irq_en       (irq_en),
    .irq          (irq),
    .press_count  (press_count),
    .cnt_clr      (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             p;
    logic             rl;
    logic             lg;
    logic             rp;
    logic             hd;
    logic [2:0]       pend;
    logic [CNT_W-1:0] cnt;
    logic             irq;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle_no = 0;

  // Behavioural model state
  bit         m_armed, m_active, m_prev;
  int         m_age;   // cycles since the accepted press
  logic [2:0] m_pend;
  int         m_cnt;
  logic [2:0] en_cur;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cycle_no, act, want);
    end
  endtask

  // One clock of stimulus plus the model's prediction for that edge.
  task automatic cyc(input logic b, input logic [2:0] pc, input logic cc, input logic r);
    exp_t e;
    bit p, rl, lg, rp;
    @(negedge clk);
    btn_debounced = b;
    pend_clr      = pc;
    cnt_clr       = cc;
    rst           = r;
    irq_en        = en_cur;
    p = 0; rl = 0; lg = 0; rp = 0;
    if (r) begin
      m_armed = 0; m_active = 0; m_prev = 0; m_age = 0;
      m_pend = '0; m_cnt = 0;
    end else begin
      if (!m_armed) begin
        if (!b) m_armed = 1;
      end else if (!m_active) begin
        if (b && !m_prev) begin
          p = 1; m_active = 1; m_age = 0;
        end
      end else if (!b) begin
        rl = 1; m_active = 0;
      end else begin
        m_age++;
        if (m_age == LONG) lg = 1;
        else if (REP_EN && m_age > LONG && ((m_age - LONG) % REPEAT) == 0) rp = 1;
      end
      m_pend = (m_pend & ~pc) | {lg, rl, (p | rp)};
      if (cc) m_cnt = (p | rp) ? 1 : 0;
      else    m_cnt = (m_cnt + int'(p | rp)) % (1 << CNT_W);
      m_prev = b;
    end
    e.p    = p;
    e.rl   = rl;
    e.lg   = lg;
    e.rp   = rp;
    e.hd   = m_active && (m_age >= LONG);
    e.pend = m_pend;
    e.cnt  = CNT_W'(m_cnt);
    e.irq  = |(m_pend & en_cur);
    sb.push_back(e);
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) cyc(b, 3'b000, 1'b0, 1'b0);
  endtask

  // Monitor: compare every clocked output set against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle_no++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("press_pulse",   int'(press_pulse),   int'(e.p));
        chk("release_pulse", int'(release_pulse), int'(e.rl));
        chk("long_pulse",    int'(long_pulse),    int'(e.lg));
        chk("repeat_pulse",  int'(repeat_pulse),  int'(e.rp));
        chk("held",          int'(held),          int'(e.hd));
        chk("pending",       int'(pending),       int'(e.pend));
        chk("press_count",   int'(press_count),   int'(e.cnt));
        chk("irq",           int'(irq),           int'(e.irq));
        if (press_pulse | release_pulse | long_pulse | repeat_pulse)
          $display("evt cyc=%0d press=%0b rel=%0b long=%0b rep=%0b pend=%03b cnt=%0d irq=%0b",
                   cycle_no, press_pulse, release_pulse, long_pulse, repeat_pulse,
                   pending, press_count, irq);
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized button activity.
  initial begin
    int n;
    rst = 1'b1; btn_debounced = 1'b0; pend_clr = '0; cnt_clr = 1'b0;
    irq_en = 3'b111; en_cur = 3'b111;

    // Button held through and after reset: must stay locked out.
    repeat (3) cyc(1'b1, 3'b000, 1'b0, 1'b1);
    hold(1'b1, 100);
    hold(1'b0, 3);
    // Short press (5 cycles high).
    hold(1'b1, 5);
    hold(1'b0, 3);
    // Long press, then release.
    hold(1'b1, 15);
    hold(1'b0, 3);
    // Fall coinciding with the long threshold.
    cyc(1'b0, 3'b111, 1'b0, 1'b0);
    hold(1'b1, LONG);
    hold(1'b0, 3);
    // Five presses to wrap the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 2);
      hold(1'b0, 2);
    end
    // Press coincident with counter clear.
    cyc(1'b1, 3'b000, 1'b1, 1'b0);
    hold(1'b1, 1);
    hold(1'b0, 2);
    // Pending clear coincident with a new press.
    cyc(1'b1, 3'b001, 1'b0, 1'b0);
    hold(1'b0, 2);
    // Masked interrupt: only pending[0] set, only release enabled.
    en_cur = 3'b010;
    cyc(1'b0, 3'b111, 1'b0, 1'b0);
    cyc(1'b1, 3'b000, 1'b0, 1'b0);
    hold(1'b1, 1);
    hold(1'b0, 2);
    en_cur = 3'b111;
    // Long hold for auto-repeat.
    cyc(1'b0, 3'b111, 1'b1, 1'b0);
    hold(1'b1, 30);
    hold(1'b0, 3);
    // Reset in PRESS and in HELD with the button still down.
    hold(1'b1, 6);
    cyc(1'b1, 3'b000, 1'b0, 1'b1);
    hold(1'b1, 5);
    hold(1'b0, 3);
    hold(1'b1, 14);
    cyc(1'b1, 3'b000, 1'b0, 1'b1);
    hold(1'b1, 4);
    hold(1'b0, 3);

    // Randomized runs of button levels with sporadic side inputs.
    for (int k = 0; k < 300; k++) begin
      n = $urandom_range(1, 35);
      if (($urandom_range(0, 7)) == 0) en_cur = 3'($urandom);
      for (int i = 0; i < n; i++) begin
        cyc(1'(k % 2 == 0),
            ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
            1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 499) == 0));
      end
    end

    hold(1'b0, 2);
    @(posedge clk);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
